fdivsqrt_r4_iter: RTL

FDIVSQRT_R4_ITER -- requirements
Module: fdivsqrt_r4_iter

---
 rtl/fdivsqrt_r4_iter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fdivsqrt_r4_iter.sv
// fdivsqrt_r4_iter -- iteration controller for a radix-4 divide / square-root
// unit. It holds the redundant residual (WS/WC), the root/quotient digit
// registers (U/UM/C) and the divisor multiples. One external combinational
// stage computes the next values each cycle while the block is BUSY.
//
// Ports
//   clk, reset          : single clock, asynchronous active-high reset
//   Start/Abort/Ack     : request (taken in IDLE only), kill, result consumed
//   SqrtIn,XIn,DIn      : operation select, initial residual, normalized divisor
//   NumIter             : number of radix-4 steps (0 is treated as 1)
//   Ready/Busy/Done     : mutually exclusive state flags
//   WS..DBar2,U,UM,C    : stage-drive outputs (held register values)
//   SqrtE, j1           : sqrt mode; first-sqrt-step marker
//   WSNext..CNext       : stage-return inputs, registered while BUSY
//   ResZero, ResNeg     : final residual zero / sign, valid while Done
//
// Configuration
//   FDIVSQRT_EARLY_TERM_EN : when defined, BUSY also finishes as soon as the
//                            stage returns a zero residual (WSNext+WCNext==0).
module fdivsqrt_r4_iter #(
  parameter int DIVB = 64,
  parameter int CNTW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Ack,
  input  logic              SqrtIn,
  input  logic [DIVB+3:0]   XIn,
  input  logic [DIVB+3:0]   DIn,
  input  logic [CNTW-1:0]   NumIter,
  output logic              Ready,
  output logic              Busy,
  output logic              Done,
  output logic [DIVB+3:0]   WS,
  output logic [DIVB+3:0]   WC,
  output logic [DIVB+3:0]   D,
  output logic [DIVB+3:0]   DBar,
  output logic [DIVB+3:0]   D2,
  output logic [DIVB+3:0]   DBar2,
  output logic [DIVB:0]     U,
  output logic [DIVB:0]     UM,
  output logic [DIVB+1:0]   C,
  output logic              SqrtE,
  output logic              j1,
  input  logic [DIVB+3:0]   WSNext,
  input  logic [DIVB+3:0]   WCNext,
  input  logic [DIVB:0]     UNext,
  input  logic [DIVB:0]     UMNext,
  input  logic [DIVB+1:0]   CNext,
  output logic              ResZero,
  output logic              ResNeg
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_next_state;
  logic [CNTW-1:0] r_cnt;
  logic [DIVB+3:0] r_ws, r_wc, r_d, r_dbar, r_d2, r_dbar2;
  logic [DIVB:0]   r_u, r_um;
  logic [DIVB+1:0] r_c;
  logic            r_sqrte, r_j1;

  logic            w_load, w_step, w_last;
  logic [DIVB+3:0] w_d2, w_res;

  // Abort kills the request and freezes the datapath in the same cycle.
  assign w_load = (r_state == S_IDLE) && Start && !Abort;
  assign w_step = (r_state == S_BUSY) && !Abort;
  assign w_d2   = {DIn[DIVB+2:0], 1'b0};

`ifdef FDIVSQRT_EARLY_TERM_EN
  logic [DIVB+3:0] w_next_sum;
  assign w_next_sum = WSNext + WCNext;
  // The zero step itself is still registered, so DONE holds a zero residual.
  assign w_last     = (r_cnt == '0) || (w_next_sum == '0);
`else
  assign w_last     = (r_cnt == '0);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its sources.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: next state gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (Start)  w_next_state = S_BUSY;
      S_BUSY:  if (w_last) w_next_state = S_DONE;
      S_DONE:  if (Ack)    w_next_state = S_IDLE;
      default:             w_next_state = S_IDLE;
    endcase
    if (Abort) w_next_state = S_IDLE;
  end

  // Counter holds (remaining steps - 1); it stops at zero instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= (NumIter == '0) ? '0 : NumIter - CNTW'(1);
    end else if (w_step && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

  // NOTE: the datapath registers are reset as well, so the stage never sees
  // X before the first load and the outputs read zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ws    <= '0;
      r_wc    <= '0;
      r_d     <= '0;
      r_dbar  <= '0;
      r_d2    <= '0;
      r_dbar2 <= '0;
      r_u     <= '0;
      r_um    <= '0;
      r_c     <= '0;
      r_sqrte <= 1'b0;
    end else if (w_load) begin
      r_ws    <= XIn;
      r_wc    <= '0;
      r_d     <= DIn;
      r_dbar  <= ~DIn;
      r_d2    <= w_d2;
      r_dbar2 <= ~w_d2;
      r_u     <= SqrtIn ? {1'b1, {DIVB{1'b0}}} : '0;
      r_um    <= '0;
      r_c     <= {2'b11, {DIVB{1'b0}}};
      r_sqrte <= SqrtIn;
    end else if (w_step) begin
      r_ws    <= WSNext;
      r_wc    <= WCNext;
      r_u     <= UNext;
      r_um    <= UMNext;
      r_c     <= CNext;
    end
  end

  // j1 is high only during the first BUSY cycle of a square root.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_j1 <= 1'b0;
    else if (w_load) r_j1 <= SqrtIn;
    else             r_j1 <= 1'b0;
  end

  assign Ready = (r_state == S_IDLE);
  assign Busy  = (r_state == S_BUSY);
  assign Done  = (r_state == S_DONE);

  assign WS    = r_ws;
  assign WC    = r_wc;
  assign D     = r_d;
  assign DBar  = r_dbar;
  assign D2    = r_d2;
  assign DBar2 = r_dbar2;
  assign U     = r_u;
  assign UM    = r_um;
  assign C     = r_c;
  assign SqrtE = r_sqrte;
  assign j1    = r_j1;

  // Residual flags are only meaningful on the held final state.
  assign w_res   = r_ws + r_wc;
  assign ResZero = Done && (w_res == '0);
  assign ResNeg  = Done && w_res[DIVB+3];

endmodule
